sgn_restore: RTL and testbench

SGN_RESTORE -- requirements
Module: sgn_restore

---
 rtl/sgn_restore.sv | 179 +++++++++++++++++
 tb/tb_sgn_restore.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sgn_restore.sv
// -----------------------------------------------------------------------------
// sgn_restore
//
// Purpose
//   Turns an unsigned product magnitude plus a sign flag into a PW-bit
//   two's-complement product (PW = 2*DATA_WIDTH). Positive results are passed
//   straight through. Negative results are negated one CHUNK_WIDTH slice per
//   cycle, rippling the +1 carry from the low chunk upward. This takes
//   N = PW/CHUNK_WIDTH cycles.
//   Alongside the result, ovf flags magnitudes that do not fit the PW-bit
//   signed range.
//
// Build option
//   SGN_RESTORE_PARALLEL_EN : when defined, negation is done full-width in the
//   accept cycle and every operand completes with single-cycle latency. The
//   NEG state is never entered. Results and ovf match the chunked build bit
//   for bit.
//
// Handshake (both sides)
//   A transfer happens on a rising Clk edge where valid and ready are both 1.
//   A source holds valid and its payload until that edge. Ready may depend
//   only on state, never combinationally on valid.
//   in_ready is 1 only in IDLE and out_valid is 1 only in DONE, so an
//   operand can never be accepted in the same cycle that a result is handed
//   off.
//
// Ports
//   Clk        in   sole clock, rising edge
//   reset      in   asynchronous, active-low reset
//   in_valid   in   P_mag/neg valid
//   in_ready   out  block is idle and will accept an operand
//   P_mag      in   [PW-1:0] unsigned magnitude
//   neg        in   1 = result must be negative
//   out_valid  out  P_signed/ovf valid
//   out_ready  in   downstream accepts result
//   P_signed   out  [PW-1:0] two's-complement result
//   ovf        out  magnitude outside the PW-bit signed range
//   state_dbg  out  [1:0] current FSM state, for checkers and debug
//
// PW must be an integer multiple of CHUNK_WIDTH.
// -----------------------------------------------------------------------------
module sgn_restore #(
  parameter int DATA_WIDTH  = 16,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                      Clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*DATA_WIDTH-1:0]   P_mag,
  input  logic                      neg,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   P_signed,
  output logic                      ovf,
  output logic [1:0]                state_dbg
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int N  = PW / CHUNK_WIDTH;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NEG  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          mag_q, mag_d;
  logic [PW-1:0]          res_q, res_d;
  logic                   ovf_q, ovf_d;
  logic [KW-1:0]          k_q, k_d;
  logic                   carry_q, carry_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [CHUNK_WIDTH:0]   chunk_sum;

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    k_d       = k_q;
    carry_d   = carry_q;
    chunk_sum = '0;

    case (state_q)
      S_IDLE: begin
        // in_ready is 1 throughout IDLE, so in_valid alone means accept.
        if (in_valid) begin
          mag_d = P_mag;
          // Negative range reaches -2^(PW-1), so exactly the MSB-only
          // magnitude still fits when neg=1.
          ovf_d = neg ? (P_mag[PW-1] & (|P_mag[PW-2:0])) : P_mag[PW-1];
          if (!neg) begin
            res_d   = P_mag;
            state_d = S_DONE;
          end else begin
`ifdef SGN_RESTORE_PARALLEL_EN
            res_d   = ~P_mag + PW'(1);
            state_d = S_DONE;
`else
            k_d     = '0;
            carry_d = 1'b1;
            state_d = S_NEG;
`endif
          end
        end
      end

      S_NEG: begin
        // One chunk of ~mag + carry per cycle. The carry-out feeds the next
        // chunk. A zero magnitude ripples the carry out of the top chunk,
        // which leaves 0 (mod 2^PW).
        for (int i = 0; i < N; i++) begin
          if (k_q == KW'(i)) begin
            chunk_sum = {1'b0, ~mag_q[i*CHUNK_WIDTH +: CHUNK_WIDTH]}
                      + {{CHUNK_WIDTH{1'b0}}, carry_q};
            res_d[i*CHUNK_WIDTH +: CHUNK_WIDTH] = chunk_sum[CHUNK_WIDTH-1:0];
            carry_d = chunk_sum[CHUNK_WIDTH];
          end
        end
        if (k_q == K_LAST) begin
          k_d     = '0;
          carry_d = 1'b0;
          state_d = S_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end

      S_DONE: begin
        // res_q/ovf_q are untouched here, so the result holds until hand-off.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake outputs are registered copies of the next-state decode.
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mag_q       <= '0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      k_q         <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      res_q       <= res_d;
      ovf_q       <= ovf_d;
      k_q         <= k_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign P_signed  = res_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sgn_restore.sv
// -----------------------------------------------------------------------------
// tb_sgn_restore
//
// Self-checking bench for sgn_restore at DATA_WIDTH=16, CHUNK_WIDTH=8.
// The reference model works on plain signed integers: +/-magnitude as a
// longint. Its low 32 bits give the result, and a range test on the same
// longint gives ovf.
//
// Latency is counted in rising edges after the accept edge until out_valid
// is seen:
//   - pass-through : 0 extra edges (valid in the cycle right after accept)
//   - chunked neg  : N edges
//   - parallel neg : 0 extra edges (SGN_RESTORE_PARALLEL_EN)
// -----------------------------------------------------------------------------
module tb_sgn_restore;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam int PW = 2 * DW;
  localparam int N  = PW / CW;
`ifdef SGN_RESTORE_PARALLEL_EN
  localparam int NEG_LAT = 0;
`else
  localparam int NEG_LAT = N;
`endif

  logic          Clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] P_mag;
  logic          neg;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] P_signed;
  logic          ovf;
  logic [1:0]    state_dbg;

  int checks;
  int errors;
  logic [PW:0] exp_q[$];
  logic [1:0]  idle_code;

  sgn_restore #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) dut (
    .Clk       (Clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .P_mag     (P_mag),
    .neg       (neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P_signed  (P_signed),
    .ovf       (ovf),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {ovf, result}.
  function automatic logic [PW:0] ref_model(input logic [PW-1:0] mag, input logic ng);
    longint v;
    logic [63:0] vb;
    logic o;
    v  = ng ? -longint'(mag) : longint'(mag);
    o  = (v > 64'sd2147483647) || (v < -64'sd2147483648);
    vb = v;
    return {o, vb[PW-1:0]};
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Present one operand, measure latency, hold the result for `hold` cycles
  // while junk operands are offered, then hand off.
  task automatic run_op(input logic [PW-1:0] mag, input logic ng, input int hold);
    int guard;
    int lat;
    logic [PW:0] e;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("in_ready_before_op", in_ready, 1);

    P_mag    = mag;
    neg      = ng;
    in_valid = 1'b1;
    exp_q.push_back(ref_model(mag, ng));
    tick();                              // accept edge
    in_valid = 1'b0;
    P_mag    = $urandom;                 // later input changes must not matter
    neg      = 1'($urandom_range(0, 1));

    lat = 0;
    while (!out_valid && lat < 40) begin
      if (lat == 1) check("dbg_busy", 64'(state_dbg != idle_code), 1);
      tick();
      lat++;
    end
    check("latency", lat, ng ? NEG_LAT : 0);

    e = exp_q.pop_front();
    check("p_signed", P_signed, e[PW-1:0]);
    check("ovf", ovf, e[PW]);

    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      P_mag    = $urandom;
      neg      = 1'($urandom_range(0, 1));
      tick();
      check("hold_p_signed", P_signed, e[PW-1:0]);
      check("hold_ovf", ovf, e[PW]);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end

    // Hand-off with in_valid also high: must not be taken as an accept.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    P_mag     = $urandom;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("handoff_out_valid", out_valid, 0);
    check("handoff_in_ready", in_ready, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [PW-1:0] m;
    bit seen_valid;
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    P_mag     = '0;
    neg       = 1'b0;

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_p_signed", P_signed, 0);
    check("rst_ovf", ovf, 0);
    idle_code = state_dbg;
    tick();
    reset = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1);

    // Directed corners
    run_op(32'h0000_1234, 1'b0, 0);
    run_op(32'h0000_0001, 1'b1, 0);
    run_op(32'h0000_0000, 1'b1, 0);
    run_op(32'h8000_0000, 1'b1, 0);
    run_op(32'h8000_0001, 1'b1, 0);
    run_op(32'h8000_0000, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 1'b1, 1);
    // Downstream stall for 5 cycles with new operands offered meanwhile
    run_op(32'h0012_3456, 1'b1, 5);

    // Reset in the middle of a chunked negation (k=2)
    P_mag    = 32'h1234_5678;
    neg      = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_p_signed", P_signed, 0);
    check("midrst_ovf", ovf, 0);
    tick();
    reset = 1'b1;
    tick();
    check("midrst_in_ready", in_ready, 1);
    seen_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      seen_valid = seen_valid | out_valid;
    end
    check("midrst_no_result", seen_valid, 0);
    run_op(32'h0000_00FF, 1'b1, 0);

    // Randomized operands, biased toward the sign/overflow boundaries
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 5))
        0:       m = 32'h0000_0000;
        1:       m = 32'h8000_0000;
        2:       m = 32'h8000_0001;
        3:       m = 32'hFFFF_FFFF;
        4:       m = $urandom & 32'h0000_01FF;
        default: m = $urandom;
      endcase
      run_op(m, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=0x0 exp=0x1");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
